// File: rtl/job_dispatcher_if.sv
// Request and controller handshake bundle for job_dispatcher.
// The master side is the request source plus controller. The slave side is the dispatcher.
interface job_dispatcher_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            req_valid;
  logic [ID_W-1:0] req_id;
  logic            req_ready;
  logic            start;
  logic            done;
  logic [ID_W-1:0] job_id;
  logic            busy;
  logic [LW-1:0]   fifo_level;
  logic [CNT_W-1:0] job_count;
  logic            timeout_err;

  modport master (
    output req_valid, req_id, done,
    input  req_ready, start, job_id, busy, fifo_level, job_count, timeout_err
  );

  modport slave (
    input  req_valid, req_id, done,
    output req_ready, start, job_id, busy, fifo_level, job_count, timeout_err
  );
endinterface

// File: rtl/job_dispatcher.sv
// Job FIFO plus issue FSM. Each job gets one start pulse, and the next job waits for done.
// Optional watchdog: define DISPATCH_TIMEOUT_EN to abandon jobs after TIMEOUT_CYC cycles in S_WAIT.
module job_dispatcher #(
  parameter int DEPTH       = 4,
  parameter int ID_W        = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           reset,
  job_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("job_dispatcher: DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop, expire, terr;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.req_valid && !full;

  // FIFO storage has no reset. The pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.req_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          terr_q;

  // A done that arrives in the expiry cycle wins, so expiry requires !done.
  assign expire = (state_q == S_WAIT) && !bus.done && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign terr   = terr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      if (state_q != S_WAIT) tmo_cnt_q <= '0;
      else if (!expire)      tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (expire) terr_q <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign terr   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          id_d    = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.done || expire) begin
          if (bus.done) cnt_d = cnt_q + 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            id_d    = mem_q[rd_ptr_q];
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready   = !full;
  assign bus.start       = (state_q == S_ISSUE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.job_id      = id_q;
  assign bus.fifo_level  = level_q;
  assign bus.job_count   = cnt_q;
  assign bus.timeout_err = terr;
endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher with DEPTH=4, ID_W=4, CNT_W=8 and TIMEOUT_CYC=16.
// A small controller model raises done two cycles after each start while auto_done is set.
module tb_job_dispatcher;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  job_dispatcher_if #(.DEPTH(4), .ID_W(4), .CNT_W(8)) bus ();

  job_dispatcher #(.DEPTH(4), .ID_W(4), .CNT_W(8), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int pend = 0;
  int dbl_start = 0;
  bit auto_done = 1'b0;
  bit prev_start = 1'b0;
  int starts[$];
  int ids[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Outputs are sampled 1ns after the edge, and inputs for the new cycle are driven here too.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_done) begin
      bus.done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) bus.done = 1'b1;
      end
      if (bus.start) pend = 2;
    end
    if (bus.start) begin
      if (prev_start) dbl_start++;
      starts.push_back(cyc);
      ids.push_back(int'(bus.job_id));
    end
    prev_start = bus.start;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_id    = 4'h3;
    bus.done      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", bus.start, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_level", bus.fifo_level, 0);
    check("rst_count", bus.job_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_jobid", bus.job_id, 0);
    check("rst_terr", bus.timeout_err, 0);

    // Idle after reset release: no start may appear without a request.
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    auto_done     = 1'b1;
    cyc           = 0;
    repeat (9) tick();
    check("idle_no_start", starts.size(), 0);

    // Single job pushed at cycle 10.
    tick();
    bus.req_valid = 1'b1;
    bus.req_id    = 4'h5;
    check("c10_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("c11_level", bus.fifo_level, 1);
    check("c11_start", bus.start, 0);
    tick();
    check("c12_start", bus.start, 1);
    check("c12_jobid", bus.job_id, 5);
    check("c12_busy", bus.busy, 1);
    check("c12_level", bus.fifo_level, 0);
    tick();
    check("c13_start", bus.start, 0);
    check("c13_busy", bus.busy, 1);
    tick();
    check("c14_busy", bus.busy, 1);
    tick();
    check("c15_count", bus.job_count, 1);
    check("c15_busy", bus.busy, 0);
    check("c15_jobid", bus.job_id, 5);

    // Back-to-back requests with ids 1, 2 and 3.
    starts.delete();
    ids.delete();
    tick(); bus.req_valid = 1'b1; bus.req_id = 4'h1;
    tick(); bus.req_id = 4'h2;
    tick(); bus.req_id = 4'h3;
    tick(); bus.req_valid = 1'b0;
    repeat (12) tick();
    check("b2b_nstart", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b_gap01", starts[1] - starts[0], 3);
      check("b2b_gap12", starts[2] - starts[1], 3);
      check("b2b_id0", ids[0], 1);
      check("b2b_id1", ids[1], 2);
      check("b2b_id2", ids[2], 3);
    end
    check("b2b_count", bus.job_count, 4);
    check("b2b_level", bus.fifo_level, 0);
    check("b2b_busy", bus.busy, 0);

    // Full FIFO: done held low while six requests arrive (ids 6 to B).
    auto_done = 1'b0;
    pend      = 0;
    bus.done  = 1'b0;
    tick(); bus.req_valid = 1'b1; bus.req_id = 4'h6;
    tick(); bus.req_id = 4'h7;
    tick(); bus.req_id = 4'h8;
    tick(); bus.req_id = 4'h9;
    tick(); bus.req_id = 4'hA;
    tick(); bus.req_id = 4'hB;
    check("full_ready", bus.req_ready, 0);
    check("full_level", bus.fifo_level, 4);
    check("full_jobid", bus.job_id, 6);
    check("full_busy", bus.busy, 1);
    tick();
    tick();
    check("full_hold_level", bus.fifo_level, 4);
    bus.done = 1'b1;
    check("full_no_passthru", bus.req_ready, 0);
    tick();
    bus.done = 1'b0;
    check("full_pop_level", bus.fifo_level, 3);
    check("full_pop_ready", bus.req_ready, 1);
    check("full_pop_start", bus.start, 1);
    check("full_pop_jobid", bus.job_id, 7);
    check("full_pop_count", bus.job_count, 5);
    tick();
    bus.req_valid = 1'b0;
    check("full_refill_level", bus.fifo_level, 4);
    check("full_refill_ready", bus.req_ready, 0);
    bus.done  = 1'b1;
    auto_done = 1'b1;
    tick();
    check("full_next_start", bus.start, 1);
    check("full_next_jobid", bus.job_id, 8);
    check("full_next_count", bus.job_count, 6);
    repeat (16) tick();
    check("drain_level", bus.fifo_level, 0);
    check("drain_count", bus.job_count, 10);
    check("drain_busy", bus.busy, 0);
    check("drain_jobid", bus.job_id, 11);

    // A done pulse while idle must be ignored.
    tick();
    bus.done = 1'b1;
    tick();
    tick();
    check("spur_count", bus.job_count, 10);
    check("spur_busy", bus.busy, 0);

    // Reset while in S_WAIT with two jobs queued.
    auto_done = 1'b0;
    pend      = 0;
    bus.done  = 1'b0;
    tick(); bus.req_valid = 1'b1; bus.req_id = 4'hC;
    tick(); bus.req_id = 4'hD;
    tick(); bus.req_id = 4'hE;
    tick(); bus.req_valid = 1'b0;
    check("mid_busy", bus.busy, 1);
    check("mid_level", bus.fifo_level, 2);
    check("mid_jobid", bus.job_id, 12);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_level", bus.fifo_level, 0);
    check("mid_rst_jobid", bus.job_id, 0);
    check("mid_rst_count", bus.job_count, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_start", bus.start, 0);
    tick();
    reset = 1'b0;
    starts.delete();
    repeat (10) tick();
    check("mid_flushed_starts", starts.size(), 0);
    check("mid_flushed_busy", bus.busy, 0);

    // Watchdog: two jobs are queued and done never arrives.
    tick(); bus.req_valid = 1'b1; bus.req_id = 4'h1;
    tick(); bus.req_id = 4'h2;
    tick(); bus.req_valid = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    repeat (15) tick();
    check("tmo_pre_err", bus.timeout_err, 0);
    check("tmo_pre_busy", bus.busy, 1);
    tick();
    check("tmo_expiry_err", bus.timeout_err, 0);
    tick();
    check("tmo_err", bus.timeout_err, 1);
    check("tmo_next_start", bus.start, 1);
    check("tmo_next_jobid", bus.job_id, 2);
    check("tmo_count", bus.job_count, 0);
`else
    repeat (20) tick();
    check("notmo_err", bus.timeout_err, 0);
    check("notmo_busy", bus.busy, 1);
    check("notmo_jobid", bus.job_id, 1);
    check("notmo_level", bus.fifo_level, 1);
    check("notmo_count", bus.job_count, 0);
`endif
    check("no_double_start", dbl_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Upstream stage of the FSM controller. Queues incoming job requests in a small FIFO and issues one single-cycle start pulse per job.
- Waits for the controller's done before issuing the next job.
- Tracks the in-flight job ID and counts completed jobs.
- Sits between the request source (valid/ready) and the controller's start/done pair.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ID_W, 4, job ID width.
- CNT_W, 8, completed-job counter width.
- TIMEOUT_CYC, 16, watchdog limit in cycles; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_id  in  ID_W  job ID of request.
- req_ready  out  1  FIFO can accept.
- start  out  1  one-cycle start pulse to controller.
- done  in  1  controller completion strobe.
- job_id  out  ID_W  ID of job currently issued/in flight.
- busy  out  1  job in flight (state S_ISSUE or S_WAIT).
- fifo_level  out  $clog2(DEPTH)+1  queued entries.
- job_count  out  CNT_W  completed jobs, wraps modulo 2^CNT_W.
- timeout_err  out  1  sticky watchdog flag.

Interface (already decided):
- One clock.
- Reset is asynchronous and active-high (clk, reset).

Behaviour:
- Reset values: start=0, busy=0, job_id=0, fifo_level=0, job_count=0, timeout_err=0, req_ready=1. FIFO pointers cleared; state=S_IDLE.
- Reset mid-operation flushes queued jobs and drops the in-flight job. The controller shares the reset.
- FIFO push: req_valid && req_ready. req_ready = !full.
- At full, req_ready is low even if a pop occurs in the same cycle; there is no full-pass-through.
- FIFO pop occurs only on an FSM issue transition. Simultaneous push and pop leaves fifo_level unchanged.
- No bypass: an entry pushed in cycle N is visible to the FSM from cycle N+1.
- S_IDLE: if FIFO non-empty, pop head into job_id and go to S_ISSUE. Otherwise stay.
- S_ISSUE: start=1 for exactly this cycle; go to S_WAIT.
- S_WAIT, done=1:
  - job_count increments.
  - If FIFO is non-empty, pop head into job_id and go directly to S_ISSUE.
  - Otherwise go to S_IDLE; job_id holds its last value.
- S_WAIT, done=0: stay.
- start is a decode of state==S_ISSUE; it is never high in two consecutive cycles.
- Latency:
  - Request accepted in cycle N with FSM idle: start in cycle N+2.
  - Controller done at cycle t with queue non-empty: next start at t+1, when the controller is back in IDLE.
  - Sustained throughput is one job per 3 cycles.
- done in S_IDLE or S_ISSUE is ignored: no count change, no state change.
- job_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in S_WAIT and clears on entry to S_WAIT.
  - If TIMEOUT_CYC cycles elapse without done, set timeout_err (sticky until reset) and abandon the job; job_count is not incremented.
  - Then proceed as on done: issue the next job if queued, otherwise go to S_IDLE.
  - done arriving in the same cycle as expiry counts as done; no error.
- Undefined: no counter is built, S_WAIT waits indefinitely, and timeout_err is tied to 0.

Test Plan:
- Reset check: assert reset with req_valid=1 -> start=0, req_ready=1, fifo_level=0, job_count=0. After release, no start until a request is accepted.
- Single job:
  - Stimulus: push id 4'h5 at cycle 10; controller model raises done 2 cycles after start.
  - Required: start=1 at cycle 12 only, job_id=5, busy high over cycles 12..14, job_count=1 at cycle 15, back to S_IDLE.
- Back-to-back jobs: push ids 1, 2, 3 in consecutive cycles -> start pulses exactly 3 cycles apart, job_id sequence 1, 2, 3, final job_count=3, fifo_level returns to 0.
- Full FIFO:
  - Stimulus: DEPTH=4, hold done low, push 6 requests.
  - Required: first request in flight, next 4 queued, req_ready=0 with fifo_level=4. The sixth request is held until the first done, accepted only after the pop frees an entry.
- Spurious done and reset mid-job:
  - done pulse while S_IDLE -> job_count unchanged.
  - Reset asserted in S_WAIT with 2 queued jobs -> all outputs return to reset values and the queued jobs are never issued.
- Timeout (with DISPATCH_TIMEOUT_EN, TIMEOUT_CYC=16): issue a job and never assert done -> timeout_err=1 after 16 cycles in S_WAIT, job_count stays 0, next queued job's start follows on the following cycle.
